tile_scheduler: RTL and testbench
=================================

TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- RAM_DEPTH, 2048, depth of the operand RAM addressed by micro_controller.
- TILE_STRIDE, 64, RAM words between consecutive tile base addresses.
- MAX_TILES, 256, maximum tiles per layer; TW = $clog2(MAX_TILES+1).
- WATCHDOG, 1023, maximum cycles a tile may run before an error is flagged.

REQ-002 Ports (name, direction, width, meaning), one per line:
- iClk, in, 1, the single clock.
- iRst, in, 1, reset, asynchronous and active-high.
- iStart, in, 1, layer start request, sampled only in IDLE.
- iTileCount, in, TW, number of tiles in the layer, captured on an accepted iStart.
- oBusy, out, 1, high in every state except IDLE.
- oDone, out, 1, single-cycle pulse at layer completion.
- oErr, out, 1, sticky watchdog error flag, cleared by the next accepted iStart.
- oMcStart, out, 1, single-cycle start pulse to micro_controller.
- iMcReady, in, 1, micro_controller idle indication.
- oBaseAddr, out, $clog2(RAM_DEPTH), base address of the current tile.
- oTileIdx, out, TW, index of the current tile.
- oDrainValid, out, 1, current tile's result is ready to drain.
- iDrainReady, in, 1, drain consumer accepts the result.

Function
REQ-003 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY, WAIT_READY, DRAIN, DONE.
REQ-004 IDLE: iStart=1 SHALL capture iTileCount, clear oTileIdx, oBaseAddr and oErr, then go to DONE if the count is 0, else to LAUNCH.
REQ-005 LAUNCH: the FSM SHALL wait until iMcReady=1, assert oMcStart for exactly that one cycle, and go to WAIT_BUSY.
REQ-006 WAIT_BUSY: iMcReady=0 SHALL move the FSM to WAIT_READY.
REQ-007 WAIT_READY: iMcReady=1 SHALL move the FSM to DRAIN.
REQ-008 The watchdog counter SHALL clear on entering WAIT_BUSY and count every cycle in WAIT_BUSY and WAIT_READY.
- On reaching WATCHDOG, oErr SHALL set and the FSM SHALL go to DRAIN (the tile is abandoned, not retried).
REQ-009 DRAIN: oDrainValid SHALL be high, with oTileIdx and oBaseAddr held stable until oDrainValid & iDrainReady.
- On that transfer, if oTileIdx = count-1 the FSM SHALL go to DONE.
- Otherwise oTileIdx SHALL increment, oBaseAddr SHALL advance by TILE_STRIDE modulo RAM_DEPTH (wrap-around, no saturation), and the FSM SHALL go to LAUNCH.
REQ-010 DONE: oDone SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-011 iStart outside IDLE SHALL be ignored, with no queuing.
REQ-012 oMcStart SHALL never be asserted more than once per tile.
REQ-013 oMcStart and oDrainValid SHALL never be high in the same cycle.
REQ-014 All outputs SHALL be registered.
REQ-015 Minimum per-tile overhead with iMcReady and iDrainReady held favourably SHALL be 4 cycles: LAUNCH, then WAIT_BUSY exiting on the first low, then WAIT_READY, then DRAIN.

Reset
REQ-016 On iRst=1 the FSM SHALL go to IDLE immediately (asynchronously), including mid-layer.
REQ-017 Reset values SHALL be: oBusy=0, oDone=0, oErr=0, oMcStart=0, oDrainValid=0, oBaseAddr=0, oTileIdx=0, watchdog counter 0.
REQ-018 The first iStart after reset release SHALL be accepted no earlier than the first rising clock edge with iRst=0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- iTileCount=3, iStart pulse, micro_controller model busy 5 cycles per tile, iDrainReady=1 -> 3 oMcStart pulses, oBaseAddr 0/64/128, single oDone, oErr=0.
- iTileCount=0, iStart pulse -> no oMcStart; oDone pulses 2 cycles after iStart; oBusy high for exactly 1 cycle.
- iDrainReady held 0 for 10 cycles during DRAIN -> oDrainValid stays high, oTileIdx/oBaseAddr unchanged, no new oMcStart.
- Model never releases busy -> oErr=1 after WATCHDOG cycles, scheduler proceeds to DRAIN; next iStart clears oErr.
- iTileCount=40 with TILE_STRIDE=64 -> tile 32 base wraps to 0; iStart pulsed mid-layer is ignored.
- iRst asserted during WAIT_READY of tile 1 -> all outputs at reset values within the same cycle; a new iStart restarts at tile 0.

Source files
------------

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks a layer tile by tile. For each tile it launches the
// micro_controller, waits for it to go busy and then idle again (under a
// watchdog), then presents the tile's result for draining before moving on.
//
// Ports:
//   iClk, iRst            clock, asynchronous active-high reset
//   iStart, iTileCount    layer start request and tile count (sampled in IDLE)
//   oBusy, oDone, oErr    status: busy, one-cycle completion pulse, sticky timeout
//   oMcStart, iMcReady    micro_controller launch pulse / idle indication
//   oBaseAddr, oTileIdx   current tile base address and index
//   oDrainValid, iDrainReady  result drain handshake
module tile_scheduler #(
  parameter int RAM_DEPTH   = 2048,
  parameter int TILE_STRIDE = 64,
  parameter int MAX_TILES   = 256,
  parameter int WATCHDOG    = 1023,
  localparam int TW  = $clog2(MAX_TILES + 1),
  localparam int AW  = $clog2(RAM_DEPTH),
  localparam int WDW = $clog2(WATCHDOG + 1)
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iStart,
  input  logic [TW-1:0] iTileCount,
  output logic          oBusy,
  output logic          oDone,
  output logic          oErr,
  output logic          oMcStart,
  input  logic          iMcReady,
  output logic [AW-1:0] oBaseAddr,
  output logic [TW-1:0] oTileIdx,
  output logic          oDrainValid,
  input  logic          iDrainReady
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_BUSY, WAIT_READY, DRAIN, DONE
  } state_t;

  state_t           state, state_n;
  logic [TW-1:0]    count;
  logic [WDW-1:0]   wdog;
  logic             accept, launch, timeout, last, advance, wd_hit;
  logic [AW:0]      base_sum;
  logic [AW-1:0]    base_nxt;

  // Stride reduced modulo depth so a single conditional subtract wraps it.
  assign base_sum = {1'b0, oBaseAddr} + (AW+1)'(TILE_STRIDE % RAM_DEPTH);
  assign base_nxt = (base_sum >= (AW+1)'(RAM_DEPTH)) ?
                    AW'(base_sum - (AW+1)'(RAM_DEPTH)) : AW'(base_sum);

  assign last   = (oTileIdx == count - TW'(1));
  // Fires on the cycle whose edge brings the count to WATCHDOG.
  assign wd_hit = (wdog == WDW'(WATCHDOG - 1));

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    launch  = 1'b0;
    timeout = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: if (iStart) begin
        accept  = 1'b1;
        state_n = (iTileCount == '0) ? DONE : LAUNCH;
      end
      LAUNCH: if (iMcReady) begin
        launch  = 1'b1;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!iMcReady)   state_n = WAIT_READY;
        else if (wd_hit) begin timeout = 1'b1; state_n = DRAIN; end
      end
      WAIT_READY: begin
        if (iMcReady)    state_n = DRAIN;
        else if (wd_hit) begin timeout = 1'b1; state_n = DRAIN; end
      end
      DRAIN: if (iDrainReady) begin
        if (last) state_n = DONE;
        else begin
          advance = 1'b1;
          state_n = LAUNCH;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state       <= IDLE;
      count       <= '0;
      wdog        <= '0;
      oTileIdx    <= '0;
      oBaseAddr   <= '0;
      oErr        <= 1'b0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oMcStart    <= 1'b0;
      oDrainValid <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        count     <= iTileCount;
        oTileIdx  <= '0;
        oBaseAddr <= '0;
        oErr      <= 1'b0;
      end
      if (advance) begin
        oTileIdx  <= oTileIdx + TW'(1);
        oBaseAddr <= base_nxt;
      end
      if (timeout) oErr <= 1'b1;
      if (launch)
        wdog <= '0;
      else if (state == WAIT_BUSY || state == WAIT_READY)
        wdog <= wdog + WDW'(1);
      // Status outputs track the state being entered; the launch pulse and
      // done pulse are registered versions of the LAUNCH exit and DONE state.
      oBusy       <= (state_n != IDLE);
      oDrainValid <= (state_n == DRAIN);
      oMcStart    <= launch;
      oDone       <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
module tb_tile_scheduler;
  localparam int TW = 9;
  localparam int AW = 11;
  localparam int WD = 1023;

  logic          iClk = 1'b0;
  logic          iRst = 1'b1;
  logic          iStart = 1'b0;
  logic [TW-1:0] iTileCount = '0;
  logic          iMcReady = 1'b1;
  logic          iDrainReady = 1'b1;
  logic          oBusy, oDone, oErr, oMcStart, oDrainValid;
  logic [AW-1:0] oBaseAddr;
  logic [TW-1:0] oTileIdx;

  tile_scheduler dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iTileCount(iTileCount),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oMcStart(oMcStart),
    .iMcReady(iMcReady), .oBaseAddr(oBaseAddr), .oTileIdx(oTileIdx),
    .oDrainValid(oDrainValid), .iDrainReady(iDrainReady)
  );

  always #5 iClk = ~iClk;

  typedef struct {bit is_done; int idx; int base; bit err;} exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int mc_cnt = 0, busy_len = 5, busy_cnt = 0;
  bit hang = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_drain(input int idx, input int base);
    exp_t e;
    e.is_done = 0; e.idx = idx; e.base = base; e.err = 0;
    sb.push_back(e);
  endtask

  task automatic push_done(input bit err);
    exp_t e;
    e.is_done = 1; e.idx = 0; e.base = 0; e.err = err;
    sb.push_back(e);
  endtask

  // micro_controller model: goes busy on a start pulse for busy_len cycles
  initial forever begin
    @(negedge iClk);
    if (iRst) begin
      iMcReady = 1'b1;
      busy_cnt = 0;
    end else if (oMcStart) begin
      mc_cnt++;
      iMcReady = 1'b0;
      busy_cnt = busy_len;
    end else if (!hang && busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) iMcReady = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every drain transfer and done pulse
  initial forever begin
    exp_t e;
    @(negedge iClk);
    #2;
    if (!iRst) begin
      if (oMcStart) chk("mcstart_vs_drainvalid", oDrainValid, 0);
      if ((oDrainValid && iDrainReady) || oDone) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event drain=%0d done=%0d idx=%0d want=none",
                   oDrainValid, oDone, oTileIdx);
        end else begin
          e = sb.pop_front();
          if (oDone) begin
            chk("done_kind", 1, e.is_done);
            chk("done_err", oErr, e.err);
          end else begin
            chk("drain_kind", 0, e.is_done);
            chk("drain_idx", oTileIdx, e.idx);
            chk("drain_base", oBaseAddr, e.base);
          end
        end
      end
    end
  end

  task automatic start(input int n);
    @(negedge iClk);
    iTileCount = TW'(n);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!oDone && k < budget) begin
      @(negedge iClk);
      k++;
    end
    if (!oDone) begin
      checks++; errors++;
      $display("FAIL wait_done timeout got=no_done want=done");
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_done"}, oDone, 0);
    chk({tag, "_err"}, oErr, 0);
    chk({tag, "_mcstart"}, oMcStart, 0);
    chk({tag, "_drainvalid"}, oDrainValid, 0);
    chk({tag, "_base"}, oBaseAddr, 0);
    chk({tag, "_idx"}, oTileIdx, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    int m0, k;
    #1;
    chk_reset_vals("rst0");
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;

    // three tiles, 5-cycle busy
    busy_len = 5;
    push_drain(0, 0); push_drain(1, 64); push_drain(2, 128); push_done(0);
    m0 = mc_cnt;
    start(3);
    wait_done(300);
    chk("s1_mc_pulses", mc_cnt - m0, 3);

    // empty layer
    push_done(0);
    m0 = mc_cnt;
    @(negedge iClk);
    iTileCount = '0; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    #1;
    chk("s2_busy_c1", oBusy, 1);
    chk("s2_done_c1", oDone, 0);
    @(negedge iClk); #1;
    chk("s2_busy_c2", oBusy, 0);
    chk("s2_done_c2", oDone, 1);
    @(negedge iClk); #1;
    chk("s2_done_c3", oDone, 0);
    chk("s2_mc_pulses", mc_cnt - m0, 0);

    // drain back-pressure
    push_drain(0, 0); push_drain(1, 64); push_done(0);
    iDrainReady = 1'b0;
    start(2);
    k = 0;
    while (!oDrainValid && k < 100) begin @(negedge iClk); k++; end
    chk("s3_reach_drain", oDrainValid, 1);
    m0 = mc_cnt;
    repeat (10) begin
      @(negedge iClk);
      chk("s3_hold_valid", oDrainValid, 1);
      chk("s3_hold_idx", oTileIdx, 0);
      chk("s3_hold_base", oBaseAddr, 0);
    end
    chk("s3_no_mc", mc_cnt - m0, 0);
    iDrainReady = 1'b1;
    wait_done(300);

    // watchdog
    hang = 1;
    push_drain(0, 0); push_done(1);
    start(1);
    k = 0;
    while (!oMcStart && k < 50) begin @(negedge iClk); k++; end
    chk("s4_launch", oMcStart, 1);
    k = 0;
    while (!oErr && k < 1100) begin @(negedge iClk); k++; end
    chk("s4_wd_cycles", k, WD);
    chk("s4_drain_after_wd", oDrainValid, 1);
    wait_done(50);
    hang = 0;
    repeat (10) @(negedge iClk);
    push_drain(0, 0); push_done(0);
    start(1);
    chk("s4_err_cleared", oErr, 0);
    wait_done(300);

    // 40 tiles, base wrap, ignored mid-layer start
    busy_len = 2;
    for (int i = 0; i < 40; i++) push_drain(i, (i * 64) % 2048);
    push_done(0);
    m0 = mc_cnt;
    start(40);
    repeat (50) @(negedge iClk);
    iTileCount = TW'(5); iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    wait_done(2000);
    repeat (5) @(negedge iClk);
    chk("s5_mc_pulses", mc_cnt - m0, 40);
    chk("s5_sb_empty", sb.size(), 0);
    chk("s5_idle", oBusy, 0);

    // reset mid-layer during WAIT_READY of tile 1
    busy_len = 5;
    push_drain(0, 0); push_drain(1, 64); push_drain(2, 128); push_done(0);
    start(3);
    k = 0;
    while (!(oMcStart && oTileIdx == 1) && k < 100) begin @(negedge iClk); k++; end
    chk("s6_tile1_launch", oTileIdx, 1);
    repeat (3) @(negedge iClk);
    #3;
    iRst = 1'b1;
    #1;
    chk_reset_vals("s6_async");
    sb.delete();
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    push_drain(0, 0); push_drain(1, 64); push_done(0);
    m0 = mc_cnt;
    start(2);
    wait_done(300);
    chk("s6_mc_pulses", mc_cnt - m0, 2);
    repeat (3) @(negedge iClk);
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
